// File: rtl/control_sequencer.sv
// Hardwired control unit that steps a single-bus datapath through fetch (T0-T2)
// and a three-register ALU execute (T3-T5), halting on an undecodable opcode.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [3:0]  alu_op,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_illegal;
    logic [15:0] r_instr_count;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [4:0]  w_decode;
    logic        w_legal;
    logic [3:0]  w_op;
    logic        w_unused_ir;

    // Returns {legal, alu_op}; anything outside the ALU opcode range is illegal.
    function automatic logic [4:0] decode_op(input logic [4:0] opcode);
        logic [4:0] result;
        case (opcode)
            5'b00011: result = {1'b1, 4'd1};
            5'b00100: result = {1'b1, 4'd2};
            5'b00101: result = {1'b1, 4'd3};
            5'b00110: result = {1'b1, 4'd4};
            5'b00111: result = {1'b1, 4'd5};
            5'b01000: result = {1'b1, 4'd6};
            5'b01001: result = {1'b1, 4'd7};
            5'b01010: result = {1'b1, 4'd8};
            5'b01011: result = {1'b1, 4'd9};
            default:  result = {1'b0, 4'd0};
        endcase
        return result;
    endfunction

    assign w_opcode    = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];
    assign w_decode    = decode_op(w_opcode);
    assign w_legal     = w_decode[4];
    assign w_op        = w_decode[3:0];

    assign illegal     = r_illegal;
    assign instr_count = r_instr_count;

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; HALT is only left through clear.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_T0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_T2;
            S_T2:   w_next_state = S_T3;
            S_T3: begin
                if (w_legal) begin
                    w_next_state = S_T4;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            S_T4:   w_next_state = S_T5;
            S_T5: begin
                if (run) begin
                    w_next_state = S_T0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobe decode; ir is only looked at in the execute states.
    always_comb begin
        PCout   = 1'b0;
        IncPC   = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Rin     = 16'h0000;
        Rout    = 16'h0000;
        alu_op  = 4'd0;
        done    = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Rout = 16'h0001 << w_rb;
                Yin  = 1'b1;
            end
            S_T4: begin
                Rout   = 16'h0001 << w_rc;
                Zin    = 1'b1;
                alu_op = w_op;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin     = 16'h0001 << w_ra;
                done    = 1'b1;
            end
            default: begin
                Rin  = 16'h0000;
                Rout = 16'h0000;
            end
        endcase
    end

    // Sticky illegal flag, raised on the T3->HALT transition.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_T3) && !w_legal) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // Completed-instruction counter, bumped on each edge leaving T5.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_instr_count <= 16'h0000;
        end else if (r_state == S_T5) begin
            r_instr_count <= r_instr_count + 16'h0001;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch/execute strobes,
// back-to-back issue, mid-instruction reset, counter wrap and illegal-opcode halt.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [3:0]  alu_op;
    logic        done;
    logic        illegal;
    logic [15:0] instr_count;

    // Strobe packing {PCout,IncPC,PCin,MARin,Read,MDRin,MDRout,IRin,Yin,Zin,Zlowout}
    localparam logic [10:0] ST_NONE = 11'b000_0000_0000;
    localparam logic [10:0] ST_T0   = 11'b110_1000_0010;
    localparam logic [10:0] ST_T1   = 11'b001_0110_0001;
    localparam logic [10:0] ST_T2   = 11'b000_0001_1000;
    localparam logic [10:0] ST_T3   = 11'b000_0000_0100;
    localparam logic [10:0] ST_T4   = 11'b000_0000_0010;
    localparam logic [10:0] ST_T5   = 11'b000_0000_0001;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_count;
    logic        exp_illegal;
    logic [10:0] w_strb;

    assign w_strb = {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout};

    control_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .ir          (ir),
        .PCout       (PCout),
        .IncPC       (IncPC),
        .PCin        (PCin),
        .MARin       (MARin),
        .Read        (Read),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .IRin        (IRin),
        .Yin         (Yin),
        .Zin         (Zin),
        .Zlowout     (Zlowout),
        .Rin         (Rin),
        .Rout        (Rout),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [10:0] e_strb, input logic [15:0] e_rin,
                           input logic [15:0] e_rout, input logic [3:0] e_alu, input logic e_done);
        check({tag, ".strb"},  {21'd0, w_strb},      {21'd0, e_strb});
        check({tag, ".rin"},   {16'd0, Rin},         {16'd0, e_rin});
        check({tag, ".rout"},  {16'd0, Rout},        {16'd0, e_rout});
        check({tag, ".alu"},   {28'd0, alu_op},      {28'd0, e_alu});
        check({tag, ".done"},  {31'd0, done},        {31'd0, e_done});
        check({tag, ".ill"},   {31'd0, illegal},     {31'd0, exp_illegal});
        check({tag, ".count"}, {16'd0, instr_count}, {16'd0, exp_count});
    endtask

    task automatic cyc(input string tag, input logic [10:0] e_strb, input logic [15:0] e_rin,
                       input logic [15:0] e_rout, input logic [3:0] e_alu, input logic e_done);
        @(negedge clock);
        chk_all(tag, e_strb, e_rin, e_rout, e_alu, e_done);
    endtask

    // Expects the next rising edge to enter T0; scrambles ir during fetch.
    task automatic do_instr(input string tag, input logic [31:0] ir_val, input logic [3:0] e_alu,
                            input logic [15:0] ra_oh, input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                            input logic run_end, input logic abort);
        cyc({tag, ".T0"}, ST_T0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        ir = 32'hFFFF_FFFF;
        cyc({tag, ".T1"}, ST_T1, 16'h0000, 16'h0000, 4'd0, 1'b0);
        ir = 32'h0000_0000;
        cyc({tag, ".T2"}, ST_T2, 16'h0000, 16'h0000, 4'd0, 1'b0);
        ir = ir_val;
        cyc({tag, ".T3"}, ST_T3, 16'h0000, rb_oh, 4'd0, 1'b0);
        cyc({tag, ".T4"}, ST_T4, 16'h0000, rc_oh, e_alu, 1'b0);
        if (abort) begin
            run = 1'b0;
            #2 clear = 1'b0;
            exp_count = 16'h0000;
            #1 chk_all({tag, ".rst"}, ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);
            @(negedge clock);
            clear = 1'b1;
        end else begin
            cyc({tag, ".T5"}, ST_T5, ra_oh, 16'h0000, 4'd0, 1'b1);
            run = run_end;
            exp_count = exp_count + 16'd1;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        exp_count   = 16'h0000;
        exp_illegal = 1'b0;
        clear       = 1'b0;
        run         = 1'b0;
        ir          = 32'h0000_0000;

        repeat (2) @(negedge clock);
        chk_all("reset", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);
        clear = 1'b1;
        cyc("idle0", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // Reset during T4: no done, no count, back to IDLE.
        run = 1'b1;
        ir  = 32'h2891_8000;
        do_instr("abort", 32'h2891_8000, 4'd3, 16'h0002, 16'h0004, 16'h0008, 1'b0, 1'b1);
        cyc("idle_rst", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // and R1,R2,R3 then run=0 -> IDLE.
        run = 1'b1;
        do_instr("and", 32'h2891_8000, 4'd3, 16'h0002, 16'h0004, 16'h0008, 1'b0, 1'b0);
        cyc("idle1", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // Two back-to-back sra: R4 <- R5 sra R6, R7 <- R8 sra R9.
        run = 1'b1;
        do_instr("sra1", {5'b01000, 4'd4, 4'd5, 4'd6, 15'd0}, 4'd6, 16'h0010, 16'h0020, 16'h0040, 1'b1, 1'b0);
        do_instr("sra2", {5'b01000, 4'd7, 4'd8, 4'd9, 15'h1234}, 4'd6, 16'h0080, 16'h0100, 16'h0200, 1'b0, 1'b0);
        cyc("idle2", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // Counter wrap from 0xFFFF; rol R15,R0,R14.
        force dut.r_instr_count = 16'hFFFF;
        #1 release dut.r_instr_count;
        exp_count = 16'hFFFF;
        check("preload", {16'd0, instr_count}, 32'h0000_FFFF);
        run = 1'b1;
        do_instr("wrap", {5'b01011, 4'd15, 4'd0, 4'd14, 15'd0}, 4'd9, 16'h8000, 16'h0001, 16'h4000, 1'b0, 1'b0);
        cyc("idle3", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // Illegal opcode: halt after T3, run ignored.
        run = 1'b1;
        ir  = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
        cyc("ill.T0", ST_T0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        cyc("ill.T1", ST_T1, 16'h0000, 16'h0000, 4'd0, 1'b0);
        cyc("ill.T2", ST_T2, 16'h0000, 16'h0000, 4'd0, 1'b0);
        cyc("ill.T3", ST_T3, 16'h0000, 16'h0004, 4'd0, 1'b0);
        exp_illegal = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc("halt", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);
        end

        // Reset clears HALT and the sticky flag.
        run = 1'b0;
        #2 clear = 1'b0;
        exp_illegal = 1'b0;
        exp_count   = 16'h0000;
        #1 chk_all("rst2", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);
        @(negedge clock);
        clear = 1'b1;
        cyc("idle4", ST_NONE, 16'h0000, 16'h0000, 4'd0, 1'b0);
        run = 1'b1;
        cyc("resume.T0", ST_T0, 16'h0000, 16'h0000, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  input  1  reset, asynchronous, active-low; clear=0 forces reset state immediately.
REQ-003 SHALL have port: run  input  1  start/continue request from test or front panel.
REQ-004 SHALL have port: ir  input  32  current IR contents; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-005 SHALL have single-bit outputs PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, each a datapath strobe of the same name.
REQ-006 SHALL have port: Rin  output  16  one-hot register-file write enable (bit n = Rn).
REQ-007 SHALL have port: Rout  output  16  one-hot register-file bus-drive enable.
REQ-008 SHALL have port: alu_op  output  4  ALU operation code, 0 = no-op.
REQ-009 SHALL have ports: done  output  1  one-cycle pulse per completed instruction; illegal  output  1  sticky illegal-opcode flag; instr_count  output  16  completed-instruction counter.

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, HALT; one state per clock.
REQ-011 SHALL transition IDLE->T0 on a rising edge with run=1, else remain in IDLE.
REQ-012 SHALL advance T0->T1->T2->T3 unconditionally.
REQ-013 SHALL, in T3, go to T4 when opcode is legal, else to HALT.
REQ-014 SHALL go T4->T5, then T5->T0 if run=1, else T5->IDLE.
REQ-015 SHALL remain in HALT until reset; run is ignored in HALT.
REQ-016 SHALL decode outputs combinationally from state and ir; every signal not listed for a state is 0.
REQ-017 SHALL drive, per state:
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], Zin, alu_op=decoded op.
- T5: Zlowout, Rin[Ra], done.
REQ-018 SHALL decode legal opcodes to alu_op: 00011 add->1, 00100 sub->2, 00101 and->3, 00110 or->4, 00111 shr->5, 01000 sra->6, 01001 shl->7, 01010 ror->8, 01011 rol->9; all other opcodes are illegal.
REQ-019 SHALL set illegal=1 on entry to HALT and hold it until reset.
REQ-020 SHALL increment instr_count by 1 on each clock edge leaving T5; 0xFFFF wraps to 0x0000.
REQ-021 SHALL sample ir only in T3-T5; ir changes during T0-T2 have no effect on outputs.
REQ-022 SHALL give 6-cycle instruction latency: done asserts in the 6th cycle after IDLE exit.
REQ-023 SHALL, for back-to-back instructions with run held at 1, leave no idle cycle between T5 and the next T0.
REQ-024 SHALL drive Rin=Rout=0 when Ra/Rb/Rc index a register and the state does not select it.

Reset
REQ-025 SHALL, on clear=0, enter IDLE asynchronously with all strobes 0, Rin=0, Rout=0, alu_op=0, done=0, illegal=0, instr_count=0.
REQ-026 SHALL abort any instruction in progress on reset mid-operation: no done pulse and no count increment.
REQ-027 SHALL resume normal sequencing from IDLE on the first rising edge after clear returns to 1.

Verification
REQ-028 SHALL pass: reset, run=1, ir=0x28918000 (and R1,R2,R3) -> T0-T5 strobes per REQ-017; T3 Rout=0x0004, T4 Rout=0x0008 and alu_op=3, T5 Rin=0x0002 and done=1; instr_count=1.
REQ-029 SHALL pass: run held at 1 for two sra instructions (opcode 01000) -> 12 consecutive cycles, alu_op=6 in each T4, no IDLE cycle between them, instr_count=2.
REQ-030 SHALL pass: opcode 11111 -> HALT after T3, illegal=1, no done pulse, run=1 ignored for 10 cycles.
REQ-031 SHALL pass: clear=0 asserted mid-T4 -> all outputs 0 before the next edge, instr_count unchanged, state IDLE.
REQ-032 SHALL pass: instr_count preloaded to 0xFFFF via 65535 instructions (or forced) -> after one more instruction, instr_count=0x0000.
REQ-033 SHALL pass: run=0 when T5 completes -> state IDLE next cycle, all strobes 0.
